// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - parametrised simple-dual-port RAM with byte lanes, RDW mode and clear sweep
//
// Purpose:
//   Generic storage bank with independent read and write ports. Writes are
//   byte-lane masked. Reads are registered, with one cycle of latency and a
//   one-cycle valid pulse. Same-address read-during-write returns either the
//   old word (RDW_MODE=0) or the merged new word (RDW_MODE=1). After reset an
//   optional sweep zeroes the whole array, one word per cycle.
//
// Ports:
//   i_clk      - clock, rising edge
//   i_rst      - asynchronous active-high reset
//   o_busy     - high while the clearing sweep runs; accesses ignored
//   i_wr_en    - write request
//   i_wr_adr   - write address
//   i_wr_dat   - write data
//   i_wr_sel   - byte-lane enables, bit i covers i_wr_dat[8i+7:8i]
//   i_rd_en    - read request
//   i_rd_adr   - read address
//   o_rd_dat   - registered read data
//   o_rd_valid - one-cycle pulse when o_rd_dat holds a new result

module mem_bank #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    output logic                      o_busy,
    input  logic                      i_wr_en,
    input  logic [ADDR_WIDTH-1:0]     i_wr_adr,
    input  logic [DATA_WIDTH-1:0]     i_wr_dat,
    input  logic [DATA_WIDTH/8-1:0]   i_wr_sel,
    input  logic                      i_rd_en,
    input  logic [ADDR_WIDTH-1:0]     i_rd_adr,
    output logic [DATA_WIDTH-1:0]     o_rd_dat,
    output logic                      o_rd_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;
    localparam logic [0:0] S_RESET = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_dat;
    logic                  r_rd_valid;

    logic                  w_ready;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_clr_we;
    logic                  w_fwd;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_ready  = (r_state == S_READY);
    assign w_wr_acc = w_ready & i_wr_en;
    assign w_rd_acc = w_ready & i_rd_en;
    // The array has no reset of its own, so every array write is held off
    // while rst is asserted; otherwise edges during a long reset pulse would
    // still update storage.
    assign w_clr_we = ~w_ready & ~i_rst;

    // Sweep sequencer: one word per cycle, leaves CLEAR after the last address.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RESET;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == {ADDR_WIDTH{1'b1}}) begin
                        r_state <= S_READY;
                    end
                end
                default: begin
                    r_state <= S_READY;
                end
            endcase
        end
    end

    // Storage: sweep zeroing or byte-masked write.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_acc && !i_rst) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (i_wr_sel[i]) begin
                    r_mem[i_wr_adr][8*i +: 8] <= i_wr_dat[8*i +: 8];
                end
            end
        end
    end

    // Post-write view of the addressed word, used only for write-first forwarding.
    always_comb begin
        w_wr_word = r_mem[i_wr_adr];
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (i_wr_sel[i]) begin
                w_wr_word[8*i +: 8] = i_wr_dat[8*i +: 8];
            end
        end
    end

    // The array read is taken before the edge's write lands, which gives
    // read-first behaviour naturally; write-first substitutes the merged word.
    assign w_fwd     = (RDW_MODE != 0) && w_wr_acc && (i_wr_adr == i_rd_adr);
    assign w_rd_word = w_fwd ? w_wr_word : r_mem[i_rd_adr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_dat   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_dat <= w_rd_word;
            end
        end
    end

    assign o_busy     = ~w_ready;
    assign o_rd_dat   = r_rd_dat;
    assign o_rd_valid = r_rd_valid;

endmodule
